cve2_fp_wb_sched: RTL and testbench
===================================

Name: cve2_fp_wb_sched

Overview:
- Write-back scheduler and scoreboard for the CVE2 floating-point register file, which has one write port (W1) and three read ports (R1/R2/R3).
- Arbitrates the FPU result stream and the LSU load stream (FLW) onto the single write port.
- Tracks in-flight destination registers and raises a RAW/WAW stall toward the decoder.
- Sits between the FP decode/issue stage, the FPU, the LSU and the FP register file.

Parameters:
- DataWidth, 32, width of FP register data.
- RV32E, 0, 1 selects a 16-entry register file (4-bit addresses); 0 selects 32 entries.
- RoundRobin, 1, 1 selects round-robin arbitration; 0 gives the LSU fixed priority.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- issue_valid_i  in  1  decoder issues an instruction that writes FP rd
- issue_rd_i  in  5  destination register of the issuing instruction
- issue_ready_o  out  1  issue accepted (rd not pending)
- ren_i  in  3  read-port enables for ports a, b, c
- raddr_a_i / raddr_b_i / raddr_c_i  in  5 each  source addresses
- stall_o  out  1  RAW hazard on an enabled read port
- fpu_valid_i  in  1  FPU result valid
- fpu_rd_i  in  5  FPU result destination
- fpu_wdata_i  in  DataWidth  FPU result data
- fpu_ready_o  out  1  FPU result granted
- lsu_valid_i  in  1  load data valid
- lsu_rd_i  in  5  load destination
- lsu_wdata_i  in  DataWidth  load data
- lsu_ready_o  out  1  load granted
- rf_waddr_o  out  5  register-file write address
- rf_wdata_o  out  DataWidth  register-file write data
- rf_we_o  out  1  register-file write enable
- fwd_sel_o  out  3  per-port forward select (see Optional Feature)
- fwd_data_o  out  DataWidth  forwarded data (see Optional Feature)

Behaviour:
- Reset (rst_ni low, asynchronous): pending scoreboard = 0, rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0, rr pointer = LSU-next, fwd_sel_o = 0, fwd_data_o = 0.
- Scoreboard: pending[NUM_WORDS-1:0], where NUM_WORDS = 2**(RV32E ? 4 : 5). Addresses are truncated to the address width. All entries are tracked, f0 included.
- Issue:
  - issue_ready_o = !pending[issue_rd_i]; this is a WAW stall and is combinational.
  - On issue_valid_i && issue_ready_o, pending[rd] is set at the next edge.
- Arbitration (combinational grant):
  - Only one valid requester: that requester is granted.
  - Both valid, RoundRobin = 1: grant goes to the requester not granted last time; the pointer updates on each dual-request grant only.
  - Both valid, RoundRobin = 0: LSU is granted.
  - x_ready_o = grant to x. The ungranted requester holds valid, rd and data stable.
- Write-back pipeline:
  - Granted rd and data are registered. rf_we_o is high in the cycle after the grant. Latency is 1 cycle; throughput is 1 write per cycle.
  - The register file applies no backpressure, so the output register is always free.
- Clear: pending[rf_waddr_o] is cleared at the edge that ends a cycle with rf_we_o = 1, i.e. the same edge at which the register file captures the data.
- Stall:
  - stall_o = OR over enabled ports of pending[raddr_x]. This is combinational and has no dependency on issue_valid_i.
  - A read in the cycle after the clearing edge sees the new data.
- Simultaneous issue and clear of the same rd in one cycle: issue_ready_o stays 0 (pending bit still set). The issue is accepted in the following cycle.
- A write-back to a non-pending rd is still written. The simulation assertion cve2_fp_wb_sched_unexpected fires.
- Reset in mid-operation drops any registered write; no write reaches the register file after reset assertion.

Optional Feature:
- Macro: CVE2_FP_WB_BYPASS_EN.
- Defined:
  - A port whose raddr equals rf_waddr_o while rf_we_o = 1 does not contribute to stall_o.
  - fwd_sel_o[x] = 1 for that port, and fwd_data_o = rf_wdata_o, so the decoder muxes the forwarded data instead of the register-file output. RAW stall is saved by one cycle.
- Undefined:
  - fwd_sel_o and fwd_data_o are tied to 0.
  - stall_o holds through the write cycle.

Decomposition:
- Package cve2_fp_wb_pkg: FpAddrW = 5; typedef fp_wb_req_t {logic valid; logic [4:0] rd; logic [DataWidth-1:0] data} sized with 32-bit default; enum wb_src_e {WB_SRC_LSU, WB_SRC_FPU}.
- Sub-module cve2_fp_wb_rr_arb: two-requester round-robin/fixed arbiter holding the last-grant state.

Test Plan:
- Issue rd = 3, then FPU writes 3 with data 0x3F800000 → issue_ready_o = 0 for a second rd = 3 until the clear; rf_we_o = 1, rf_waddr_o = 3, rf_wdata_o = 0x3F800000 one cycle after fpu_ready_o.
- FPU (rd = 5) and LSU (rd = 6) valid together for 4 cycles, RoundRobin = 1 → grants alternate LSU, FPU, LSU, FPU; RoundRobin = 0 → LSU wins until lsu_valid_i drops.
- Pending rd = 7 with ren_i = 3'b010 and raddr_b_i = 7 → stall_o = 1 until the cycle after rf_we_o for 7. With CVE2_FP_WB_BYPASS_EN: stall_o = 0 in the rf_we_o cycle and fwd_sel_o = 3'b010.
- RV32E = 1, issue rd = 18 → scoreboard entry 2 is set (truncated address); read of address 2 stalls.
- Assert rst_ni low while rf_we_o = 1 → rf_we_o = 0 immediately, all pending cleared, and issue_ready_o = 1 after release.
- Issue rd = 9 in the same cycle that rf_we_o clears 9 → issue_ready_o = 0 that cycle, 1 the next; pending[9] ends set.

Source files
------------

// File: rtl/cve2_fp_wb_pkg.sv
// Shared types and constants for the CVE2 floating-point write-back scheduler.
package cve2_fp_wb_pkg;

   // Architectural FP register address width (f0..f31).
   localparam int unsigned FpAddrW = 5;

   // Default FP data width used to size the request record.
   localparam int unsigned FpDataW = 32;

   // One write-back request as presented by the FPU or the LSU.
   typedef struct packed {
      logic               valid;
      logic [FpAddrW-1:0] rd;
      logic [FpDataW-1:0] data;
   } fp_wb_req_t;

   // Write-back source selected by the arbiter.
   typedef enum logic {
      WB_SRC_LSU = 1'b0,
      WB_SRC_FPU = 1'b1
   } wb_src_e;

endpackage

// File: rtl/cve2_fp_wb_rr_arb.sv
// Two-requester write-port arbiter (LSU vs FPU).
// RoundRobin != 0: on a dual request the requester not granted at the previous
// dual request wins; the pointer only moves on dual requests and starts on LSU.
// RoundRobin == 0: the LSU always wins a dual request.
module cve2_fp_wb_rr_arb
   import cve2_fp_wb_pkg::*;
#(
   parameter int unsigned RoundRobin = 1
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   input  logic    lsu_req,
   input  logic    fpu_req,
   output logic    lsu_gnt,
   output logic    fpu_gnt,
   output wb_src_e src
);

   // Requester that wins the next dual request.
   wb_src_e prio_q;

   // Grant decode: a lone requester always wins, a dual request follows the pointer.
   always_comb begin
      lsu_gnt = 1'b0;
      fpu_gnt = 1'b0;
      if (lsu_req && fpu_req) begin
         if ((RoundRobin != 0) && (prio_q == WB_SRC_FPU)) begin
            fpu_gnt = 1'b1;
         end else begin
            lsu_gnt = 1'b1;
         end
      end else if (lsu_req) begin
         lsu_gnt = 1'b1;
      end else if (fpu_req) begin
         fpu_gnt = 1'b1;
      end else begin
         lsu_gnt = 1'b0;
         fpu_gnt = 1'b0;
      end
   end

   assign src = fpu_gnt ? WB_SRC_FPU : WB_SRC_LSU;

   // Priority pointer: hand the next dual request to the loser of this one.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prio_q <= WB_SRC_LSU;
      end else if (lsu_req && fpu_req) begin
         prio_q <= fpu_gnt ? WB_SRC_LSU : WB_SRC_FPU;
      end
   end

endmodule

// File: rtl/cve2_fp_wb_sched_chk.sv
// Simulation checks for the FP write-back scheduler: every register-file write
// is expected to retire a destination that the scoreboard marked as in flight.
module cve2_fp_wb_sched_chk (
   input logic clk_i,
   input logic rst_ni,
   input logic rf_we,
   input logic wb_pending
);

   cve2_fp_wb_sched_unexpected: assert property (
      @(posedge clk_i) disable iff (!rst_ni) rf_we |-> wb_pending
   );

endmodule

// File: rtl/cve2_fp_wb_sched.sv
// Write-back scheduler and scoreboard for the CVE2 FP register file.
// Merges the FPU result stream and the LSU load stream onto the single write
// port (1-cycle registered latency), tracks pending destinations and raises
// WAW (issue_ready_o) and RAW (stall_o) hazards toward the decoder.
// Optional feature: define CVE2_FP_WB_BYPASS_EN to forward the data being
// written this cycle to matching read ports instead of stalling them.
module cve2_fp_wb_sched
   import cve2_fp_wb_pkg::*;
#(
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned RV32E      = 0,
   parameter int unsigned RoundRobin = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 issue_valid_i,
   input  logic [FpAddrW-1:0]   issue_rd_i,
   output logic                 issue_ready_o,
   input  logic [2:0]           ren_i,
   input  logic [FpAddrW-1:0]   raddr_a_i,
   input  logic [FpAddrW-1:0]   raddr_b_i,
   input  logic [FpAddrW-1:0]   raddr_c_i,
   output logic                 stall_o,
   input  logic                 fpu_valid_i,
   input  logic [FpAddrW-1:0]   fpu_rd_i,
   input  logic [DataWidth-1:0] fpu_wdata_i,
   output logic                 fpu_ready_o,
   input  logic                 lsu_valid_i,
   input  logic [FpAddrW-1:0]   lsu_rd_i,
   input  logic [DataWidth-1:0] lsu_wdata_i,
   output logic                 lsu_ready_o,
   output logic [FpAddrW-1:0]   rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o,
   output logic                 rf_we_o,
   output logic [2:0]           fwd_sel_o,
   output logic [DataWidth-1:0] fwd_data_o
);

   localparam int unsigned AddrW    = (RV32E != 0) ? 4 : 5;
   localparam int unsigned NumWords = 2 ** AddrW;

   logic [NumWords-1:0]  pending_q;
   logic [NumWords-1:0]  pending_d;
   logic [NumWords-1:0]  set_mask;
   logic [NumWords-1:0]  clr_mask;
   logic [AddrW-1:0]     issue_idx;
   logic [AddrW-1:0]     wb_idx;
   logic [AddrW-1:0]     rd_idx [3];
   logic                 issue_fire;
   logic                 lsu_gnt;
   logic                 fpu_gnt;
   logic                 gnt_any;
   wb_src_e              wb_src;
   logic [FpAddrW-1:0]   gnt_rd;
   logic [DataWidth-1:0] gnt_data;
   logic [2:0]           hit;
   logic [2:0]           byp;

   // Scoreboard indices: addresses are truncated to the register-file size.
   assign issue_idx = issue_rd_i[AddrW-1:0];
   assign wb_idx    = rf_waddr_o[AddrW-1:0];
   assign rd_idx[0] = raddr_a_i[AddrW-1:0];
   assign rd_idx[1] = raddr_b_i[AddrW-1:0];
   assign rd_idx[2] = raddr_c_i[AddrW-1:0];

   // A pending destination blocks a new writer of the same register (WAW).
   assign issue_ready_o = ~pending_q[issue_idx];
   assign issue_fire    = issue_valid_i & issue_ready_o;

   // Scoreboard update masks: set on accepted issue, clear on the write edge.
   always_comb begin
      set_mask = {NumWords{1'b0}};
      clr_mask = {NumWords{1'b0}};
      if (issue_fire) begin
         set_mask[issue_idx] = 1'b1;
      end else begin
         set_mask = {NumWords{1'b0}};
      end
      if (rf_we_o) begin
         clr_mask[wb_idx] = 1'b1;
      end else begin
         clr_mask = {NumWords{1'b0}};
      end
      pending_d = (pending_q & ~clr_mask) | set_mask;
   end

   // Scoreboard register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q <= {NumWords{1'b0}};
      end else begin
         pending_q <= pending_d;
      end
   end

   cve2_fp_wb_rr_arb #(
      .RoundRobin (RoundRobin)
   ) u_arb (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .lsu_req (lsu_valid_i),
      .fpu_req (fpu_valid_i),
      .lsu_gnt (lsu_gnt),
      .fpu_gnt (fpu_gnt),
      .src     (wb_src)
   );

   assign lsu_ready_o = lsu_gnt;
   assign fpu_ready_o = fpu_gnt;
   assign gnt_any     = lsu_gnt | fpu_gnt;
   assign gnt_rd      = (wb_src == WB_SRC_FPU) ? fpu_rd_i    : lsu_rd_i;
   assign gnt_data    = (wb_src == WB_SRC_FPU) ? fpu_wdata_i : lsu_wdata_i;

   // Write-back stage: capture the granted request for next-cycle write.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rf_we_o    <= 1'b0;
         rf_waddr_o <= {FpAddrW{1'b0}};
         rf_wdata_o <= {DataWidth{1'b0}};
      end else begin
         rf_we_o <= gnt_any;
         if (gnt_any) begin
            rf_waddr_o <= gnt_rd;
            rf_wdata_o <= gnt_data;
         end
      end
   end

   // Per-port RAW hit and (optionally) write-cycle bypass match.
   always_comb begin
      hit = 3'b000;
      byp = 3'b000;
      for (int i = 0; i < 3; i++) begin
         hit[i] = ren_i[i] & pending_q[rd_idx[i]];
`ifdef CVE2_FP_WB_BYPASS_EN
         byp[i] = ren_i[i] & rf_we_o & (rd_idx[i] == wb_idx);
`endif
      end
   end

   // A bypassed port reads the forwarded data and need not wait for the write.
   assign stall_o = |(hit & ~byp);

`ifdef CVE2_FP_WB_BYPASS_EN
   assign fwd_sel_o  = byp;
   assign fwd_data_o = rf_wdata_o;
`else
   assign fwd_sel_o  = 3'b000;
   assign fwd_data_o = {DataWidth{1'b0}};
`endif

   cve2_fp_wb_sched_chk u_chk (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .rf_we      (rf_we_o),
      .wb_pending (pending_q[wb_idx])
   );

endmodule

// File: tb/tb_cve2_fp_wb_sched.sv
// Directed self-checking bench for cve2_fp_wb_sched.
// Instance 0: default (round robin), 1: fixed LSU priority, 2: RV32E.
module tb_cve2_fp_wb_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        iv [3];
   logic        fv [3];
   logic        lv [3];
   logic [4:0]  issue_rd = 5'd0;
   logic [2:0]  ren = 3'b000;
   logic [4:0]  raddr_a = 5'd0;
   logic [4:0]  raddr_b = 5'd0;
   logic [4:0]  raddr_c = 5'd0;
   logic [4:0]  fpu_rd = 5'd0;
   logic [31:0] fpu_wdata = 32'd0;
   logic [4:0]  lsu_rd = 5'd0;
   logic [31:0] lsu_wdata = 32'd0;

   logic        issue_ready [3];
   logic        stall [3];
   logic        fpu_ready [3];
   logic        lsu_ready [3];
   logic [4:0]  rf_waddr [3];
   logic [31:0] rf_wdata [3];
   logic        rf_we [3];
   logic [2:0]  fwd_sel [3];
   logic [31:0] fwd_data [3];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cve2_fp_wb_sched #(.DataWidth(32), .RV32E(0), .RoundRobin(1)) u_rr (
      .clk_i(clk), .rst_ni(rst_n),
      .issue_valid_i(iv[0]), .issue_rd_i(issue_rd), .issue_ready_o(issue_ready[0]),
      .ren_i(ren), .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .raddr_c_i(raddr_c),
      .stall_o(stall[0]),
      .fpu_valid_i(fv[0]), .fpu_rd_i(fpu_rd), .fpu_wdata_i(fpu_wdata), .fpu_ready_o(fpu_ready[0]),
      .lsu_valid_i(lv[0]), .lsu_rd_i(lsu_rd), .lsu_wdata_i(lsu_wdata), .lsu_ready_o(lsu_ready[0]),
      .rf_waddr_o(rf_waddr[0]), .rf_wdata_o(rf_wdata[0]), .rf_we_o(rf_we[0]),
      .fwd_sel_o(fwd_sel[0]), .fwd_data_o(fwd_data[0])
   );

   cve2_fp_wb_sched #(.DataWidth(32), .RV32E(0), .RoundRobin(0)) u_fix (
      .clk_i(clk), .rst_ni(rst_n),
      .issue_valid_i(iv[1]), .issue_rd_i(issue_rd), .issue_ready_o(issue_ready[1]),
      .ren_i(ren), .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .raddr_c_i(raddr_c),
      .stall_o(stall[1]),
      .fpu_valid_i(fv[1]), .fpu_rd_i(fpu_rd), .fpu_wdata_i(fpu_wdata), .fpu_ready_o(fpu_ready[1]),
      .lsu_valid_i(lv[1]), .lsu_rd_i(lsu_rd), .lsu_wdata_i(lsu_wdata), .lsu_ready_o(lsu_ready[1]),
      .rf_waddr_o(rf_waddr[1]), .rf_wdata_o(rf_wdata[1]), .rf_we_o(rf_we[1]),
      .fwd_sel_o(fwd_sel[1]), .fwd_data_o(fwd_data[1])
   );

   cve2_fp_wb_sched #(.DataWidth(32), .RV32E(1), .RoundRobin(1)) u_e (
      .clk_i(clk), .rst_ni(rst_n),
      .issue_valid_i(iv[2]), .issue_rd_i(issue_rd), .issue_ready_o(issue_ready[2]),
      .ren_i(ren), .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .raddr_c_i(raddr_c),
      .stall_o(stall[2]),
      .fpu_valid_i(fv[2]), .fpu_rd_i(fpu_rd), .fpu_wdata_i(fpu_wdata), .fpu_ready_o(fpu_ready[2]),
      .lsu_valid_i(lv[2]), .lsu_rd_i(lsu_rd), .lsu_wdata_i(lsu_wdata), .lsu_ready_o(lsu_ready[2]),
      .rf_waddr_o(rf_waddr[2]), .rf_wdata_o(rf_wdata[2]), .rf_we_o(rf_we[2]),
      .fwd_sel_o(fwd_sel[2]), .fwd_data_o(fwd_data[2])
   );

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ren = 3'b111;
      raddr_a = 5'd1; raddr_b = 5'd2; raddr_c = 5'd3;
      issue_rd = 5'd0;
      cyc(); cyc();
      #1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (rf_we[i] !== 1'b0) begin n_err++; $display("FAIL reset_we[%0d]: got %b want 0", i, rf_we[i]); end
         n_cmp++; if (rf_waddr[i] !== 5'd0) begin n_err++; $display("FAIL reset_waddr[%0d]: got %0d want 0", i, rf_waddr[i]); end
         n_cmp++; if (rf_wdata[i] !== 32'd0) begin n_err++; $display("FAIL reset_wdata[%0d]: got %h want 0", i, rf_wdata[i]); end
         n_cmp++; if (fwd_sel[i] !== 3'b000) begin n_err++; $display("FAIL reset_fwd_sel[%0d]: got %b want 000", i, fwd_sel[i]); end
         n_cmp++; if (fwd_data[i] !== 32'd0) begin n_err++; $display("FAIL reset_fwd_data[%0d]: got %h want 0", i, fwd_data[i]); end
         n_cmp++; if (issue_ready[i] !== 1'b1) begin n_err++; $display("FAIL reset_issue_ready[%0d]: got %b want 1", i, issue_ready[i]); end
         n_cmp++; if (stall[i] !== 1'b0) begin n_err++; $display("FAIL reset_stall[%0d]: got %b want 0", i, stall[i]); end
      end
      rst_n = 1'b1;
      ren = 3'b000;
      cyc();
   endtask

   task automatic test_fpu_write();
      issue_rd = 5'd3; iv[0] = 1'b1;
      #1;
      n_cmp++; if (issue_ready[0] !== 1'b1) begin n_err++; $display("FAIL fw_issue_ready_first: got %b want 1", issue_ready[0]); end
      cyc();
      iv[0] = 1'b0;
      fv[0] = 1'b1; fpu_rd = 5'd3; fpu_wdata = 32'h3F800000;
      #1;
      n_cmp++; if (issue_ready[0] !== 1'b0) begin n_err++; $display("FAIL fw_waw_block: got %b want 0", issue_ready[0]); end
      n_cmp++; if (fpu_ready[0] !== 1'b1) begin n_err++; $display("FAIL fw_fpu_ready: got %b want 1", fpu_ready[0]); end
      n_cmp++; if (rf_we[0] !== 1'b0) begin n_err++; $display("FAIL fw_we_early: got %b want 0", rf_we[0]); end
      cyc();
      fv[0] = 1'b0;
      #1;
      n_cmp++; if (rf_we[0] !== 1'b1) begin n_err++; $display("FAIL fw_we: got %b want 1", rf_we[0]); end
      n_cmp++; if (rf_waddr[0] !== 5'd3) begin n_err++; $display("FAIL fw_waddr: got %0d want 3", rf_waddr[0]); end
      n_cmp++; if (rf_wdata[0] !== 32'h3F800000) begin n_err++; $display("FAIL fw_wdata: got %h want 3f800000", rf_wdata[0]); end
      n_cmp++; if (issue_ready[0] !== 1'b0) begin n_err++; $display("FAIL fw_waw_write_cycle: got %b want 0", issue_ready[0]); end
      cyc();
      #1;
      n_cmp++; if (rf_we[0] !== 1'b0) begin n_err++; $display("FAIL fw_we_after: got %b want 0", rf_we[0]); end
      n_cmp++; if (issue_ready[0] !== 1'b1) begin n_err++; $display("FAIL fw_issue_after_clear: got %b want 1", issue_ready[0]); end
      cyc();
   endtask

   task automatic test_round_robin();
      int lsu_n;
      int fpu_n;
      int last_rd;
      logic exp_l;
      for (int r = 10; r < 18; r++) begin
         issue_rd = 5'(r); iv[0] = 1'b1;
         #1;
         n_cmp++; if (issue_ready[0] !== 1'b1) begin n_err++; $display("FAIL rr_issue %0d: got %b want 1", r, issue_ready[0]); end
         cyc();
      end
      iv[0] = 1'b0;
      lsu_n = 10; fpu_n = 14; last_rd = 0;
      lv[0] = 1'b1; fv[0] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         lsu_rd = 5'(lsu_n); lsu_wdata = 32'hA000_0000 + 32'(lsu_n);
         fpu_rd = 5'(fpu_n); fpu_wdata = 32'hB000_0000 + 32'(fpu_n);
         exp_l = ((k % 2) == 0);
         #1;
         n_cmp++; if (lsu_ready[0] !== exp_l) begin n_err++; $display("FAIL rr_lsu_gnt k=%0d: got %b want %b", k, lsu_ready[0], exp_l); end
         n_cmp++; if (fpu_ready[0] !== !exp_l) begin n_err++; $display("FAIL rr_fpu_gnt k=%0d: got %b want %b", k, fpu_ready[0], !exp_l); end
         if (k > 0) begin
            n_cmp++; if (rf_waddr[0] !== 5'(last_rd)) begin n_err++; $display("FAIL rr_waddr k=%0d: got %0d want %0d", k, rf_waddr[0], last_rd); end
         end
         if (exp_l) begin last_rd = lsu_n; lsu_n++; end
         else begin last_rd = fpu_n; fpu_n++; end
         cyc();
      end
      lv[0] = 1'b0; fv[0] = 1'b0;
      #1;
      n_cmp++; if (rf_waddr[0] !== 5'd17) begin n_err++; $display("FAIL rr_last_waddr: got %0d want 17", rf_waddr[0]); end
      n_cmp++; if (rf_wdata[0] !== 32'hB000_0011) begin n_err++; $display("FAIL rr_last_wdata: got %h want b0000011", rf_wdata[0]); end
      cyc();
   endtask

   task automatic test_fixed_priority();
      logic [4:0] regs [4];
      regs[0] = 5'd10; regs[1] = 5'd11; regs[2] = 5'd12; regs[3] = 5'd14;
      for (int r = 0; r < 4; r++) begin
         issue_rd = regs[r]; iv[1] = 1'b1;
         cyc();
      end
      iv[1] = 1'b0;
      lv[1] = 1'b1; fv[1] = 1'b1;
      fpu_rd = 5'd14; fpu_wdata = 32'h1111_1111;
      for (int k = 0; k < 3; k++) begin
         lsu_rd = 5'(10 + k); lsu_wdata = 32'h2222_0000 + 32'(k);
         #1;
         n_cmp++; if (lsu_ready[1] !== 1'b1) begin n_err++; $display("FAIL fix_lsu_gnt k=%0d: got %b want 1", k, lsu_ready[1]); end
         n_cmp++; if (fpu_ready[1] !== 1'b0) begin n_err++; $display("FAIL fix_fpu_hold k=%0d: got %b want 0", k, fpu_ready[1]); end
         cyc();
      end
      lv[1] = 1'b0;
      #1;
      n_cmp++; if (fpu_ready[1] !== 1'b1) begin n_err++; $display("FAIL fix_fpu_gnt: got %b want 1", fpu_ready[1]); end
      n_cmp++; if (rf_waddr[1] !== 5'd12) begin n_err++; $display("FAIL fix_waddr_lsu: got %0d want 12", rf_waddr[1]); end
      cyc();
      fv[1] = 1'b0;
      #1;
      n_cmp++; if (rf_waddr[1] !== 5'd14) begin n_err++; $display("FAIL fix_waddr_fpu: got %0d want 14", rf_waddr[1]); end
      n_cmp++; if (rf_wdata[1] !== 32'h1111_1111) begin n_err++; $display("FAIL fix_wdata_fpu: got %h want 11111111", rf_wdata[1]); end
      cyc();
   endtask

   task automatic test_raw_stall();
      issue_rd = 5'd7; iv[0] = 1'b1;
      cyc();
      iv[0] = 1'b0;
      raddr_a = 5'd7; raddr_b = 5'd7; raddr_c = 5'd7;
      ren = 3'b101;
      #1;
      n_cmp++; if (stall[0] !== 1'b1) begin n_err++; $display("FAIL raw_stall_ac: got %b want 1", stall[0]); end
      raddr_a = 5'd1; raddr_c = 5'd2;
      #1;
      n_cmp++; if (stall[0] !== 1'b0) begin n_err++; $display("FAIL raw_disabled_port: got %b want 0", stall[0]); end
      ren = 3'b010;
      fv[0] = 1'b1; fpu_rd = 5'd7; fpu_wdata = 32'h40490FDB;
      #1;
      n_cmp++; if (stall[0] !== 1'b1) begin n_err++; $display("FAIL raw_stall_b: got %b want 1", stall[0]); end
      cyc();
      fv[0] = 1'b0;
      #1;
      n_cmp++; if (rf_we[0] !== 1'b1) begin n_err++; $display("FAIL raw_we: got %b want 1", rf_we[0]); end
`ifdef CVE2_FP_WB_BYPASS_EN
      n_cmp++; if (stall[0] !== 1'b0) begin n_err++; $display("FAIL raw_byp_stall: got %b want 0", stall[0]); end
      n_cmp++; if (fwd_sel[0] !== 3'b010) begin n_err++; $display("FAIL raw_byp_sel: got %b want 010", fwd_sel[0]); end
      n_cmp++; if (fwd_data[0] !== 32'h40490FDB) begin n_err++; $display("FAIL raw_byp_data: got %h want 40490fdb", fwd_data[0]); end
`else
      n_cmp++; if (stall[0] !== 1'b1) begin n_err++; $display("FAIL raw_stall_write_cycle: got %b want 1", stall[0]); end
      n_cmp++; if (fwd_sel[0] !== 3'b000) begin n_err++; $display("FAIL raw_fwd_sel: got %b want 000", fwd_sel[0]); end
      n_cmp++; if (fwd_data[0] !== 32'd0) begin n_err++; $display("FAIL raw_fwd_data: got %h want 0", fwd_data[0]); end
`endif
      cyc();
      #1;
      n_cmp++; if (stall[0] !== 1'b0) begin n_err++; $display("FAIL raw_stall_after: got %b want 0", stall[0]); end
      n_cmp++; if (fwd_sel[0] !== 3'b000) begin n_err++; $display("FAIL raw_fwd_after: got %b want 000", fwd_sel[0]); end
      ren = 3'b000;
      cyc();
   endtask

   task automatic test_rv32e();
      issue_rd = 5'd18; iv[2] = 1'b1;
      #1;
      n_cmp++; if (issue_ready[2] !== 1'b1) begin n_err++; $display("FAIL e_issue: got %b want 1", issue_ready[2]); end
      cyc();
      iv[2] = 1'b0;
      issue_rd = 5'd2;
      ren = 3'b001; raddr_a = 5'd2;
      #1;
      n_cmp++; if (stall[2] !== 1'b1) begin n_err++; $display("FAIL e_stall_2: got %b want 1", stall[2]); end
      n_cmp++; if (issue_ready[2] !== 1'b0) begin n_err++; $display("FAIL e_waw_2: got %b want 0", issue_ready[2]); end
      raddr_a = 5'd3;
      #1;
      n_cmp++; if (stall[2] !== 1'b0) begin n_err++; $display("FAIL e_stall_3: got %b want 0", stall[2]); end
      fv[2] = 1'b1; fpu_rd = 5'd18; fpu_wdata = 32'hC0000000;
      cyc();
      fv[2] = 1'b0;
      raddr_a = 5'd2;
      #1;
      n_cmp++; if (rf_we[2] !== 1'b1) begin n_err++; $display("FAIL e_we: got %b want 1", rf_we[2]); end
      cyc();
      #1;
      n_cmp++; if (stall[2] !== 1'b0) begin n_err++; $display("FAIL e_stall_cleared: got %b want 0", stall[2]); end
      ren = 3'b000;
      cyc();
   endtask

   task automatic test_reset_mid();
      issue_rd = 5'd20; iv[0] = 1'b1;
      cyc();
      issue_rd = 5'd21;
      fv[0] = 1'b1; fpu_rd = 5'd20; fpu_wdata = 32'h5555AAAA;
      cyc();
      iv[0] = 1'b0; fv[0] = 1'b0;
      #1;
      n_cmp++; if (rf_we[0] !== 1'b1) begin n_err++; $display("FAIL rm_we_before: got %b want 1", rf_we[0]); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (rf_we[0] !== 1'b0) begin n_err++; $display("FAIL rm_we_in_reset: got %b want 0", rf_we[0]); end
      cyc();
      rst_n = 1'b1;
      #1;
      n_cmp++; if (issue_ready[0] !== 1'b1) begin n_err++; $display("FAIL rm_pending21_cleared: got %b want 1", issue_ready[0]); end
      issue_rd = 5'd20;
      #1;
      n_cmp++; if (issue_ready[0] !== 1'b1) begin n_err++; $display("FAIL rm_pending20_cleared: got %b want 1", issue_ready[0]); end
      cyc();
      n_cmp++; if (rf_we[0] !== 1'b0) begin n_err++; $display("FAIL rm_no_write_after: got %b want 0", rf_we[0]); end
      cyc();
   endtask

   task automatic test_issue_clear_same();
      issue_rd = 5'd9; iv[0] = 1'b1;
      cyc();
      iv[0] = 1'b0;
      fv[0] = 1'b1; fpu_rd = 5'd9; fpu_wdata = 32'h00000009;
      cyc();
      fv[0] = 1'b0;
      iv[0] = 1'b1;
      #1;
      n_cmp++; if (rf_we[0] !== 1'b1) begin n_err++; $display("FAIL ic_we: got %b want 1", rf_we[0]); end
      n_cmp++; if (issue_ready[0] !== 1'b0) begin n_err++; $display("FAIL ic_ready_clear_cycle: got %b want 0", issue_ready[0]); end
      cyc();
      #1;
      n_cmp++; if (issue_ready[0] !== 1'b1) begin n_err++; $display("FAIL ic_ready_next: got %b want 1", issue_ready[0]); end
      cyc();
      iv[0] = 1'b0;
      ren = 3'b100; raddr_c = 5'd9;
      #1;
      n_cmp++; if (issue_ready[0] !== 1'b0) begin n_err++; $display("FAIL ic_pending_set: got %b want 0", issue_ready[0]); end
      n_cmp++; if (stall[0] !== 1'b1) begin n_err++; $display("FAIL ic_stall: got %b want 1", stall[0]); end
      fv[0] = 1'b1;
      cyc();
      fv[0] = 1'b0;
      cyc();
      #1;
      n_cmp++; if (stall[0] !== 1'b0) begin n_err++; $display("FAIL ic_drained: got %b want 0", stall[0]); end
      ren = 3'b000;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         iv[i] = 1'b0; fv[i] = 1'b0; lv[i] = 1'b0;
      end
      test_reset();
      test_fpu_write();
      test_round_robin();
      test_fixed_priority();
      test_raw_stall();
      test_rv32e();
      test_reset_mid();
      test_issue_clear_same();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
